// File: rtl/blink_sequencer.sv
// blink_sequencer: LED blink sequencer with ms-tick prescaler; BLINK_SEQ_ABORT_EN adds i_abort
module blink_sequencer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1_000,
  parameter int MS_W    = 16,
  parameter int CNT_W   = 8
) (
  input  logic             i_clk_100MHz,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  input  logic [MS_W-1:0]  i_on_ms,
  input  logic [MS_W-1:0]  i_off_ms,
`ifdef BLINK_SEQ_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_led,
  output logic             o_busy,
  output logic             o_done
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;
  state_t state, next;
  logic [PW-1:0] presc;
  logic [MS_W-1:0] ticks, on_len, off_len;
  logic [CNT_W-1:0] blinks;
  logic tick, phase_end, abort;
`ifdef BLINK_SEQ_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif
  assign tick = presc == PW'(TICK_DIV - 1);
  assign phase_end = tick && ticks == ((state == ON) ? on_len : off_len) - MS_W'(1);
  always_ff @(posedge i_clk_100MHz or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: if (i_start) next = (i_count != '0) ? ON : DONE;
      ON:   next = abort ? DONE : phase_end ? ((blinks == CNT_W'(1)) ? DONE : OFF) : ON;
      OFF:  next = abort ? DONE : phase_end ? ON : OFF;
      DONE: next = IDLE;
    endcase
  end
  // counters restart on accept and on every phase change so each phase is exactly ms*TICK_DIV cycles
  always_ff @(posedge i_clk_100MHz or posedge i_rst)
    if (i_rst) begin
      presc   <= '0;
      ticks   <= '0;
      blinks  <= '0;
      on_len  <= '0;
      off_len <= '0;
    end else begin
      if (state == IDLE && i_start) begin
        blinks  <= i_count;
        on_len  <= (i_on_ms == '0) ? MS_W'(1) : i_on_ms;
        off_len <= (i_off_ms == '0) ? MS_W'(1) : i_off_ms;
      end
      if (state == IDLE || next != state) begin
        presc <= '0;
        ticks <= '0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) ticks <= ticks + MS_W'(1);
      end
      if (state == ON && phase_end) blinks <= blinks - CNT_W'(1);
    end
  always_comb begin
    o_led  = state == ON;
    o_busy = state != IDLE;
    o_done = state == DONE;
  end
endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: directed checks of blink timing, handshake, reset and abort
module tb_blink_sequencer;
  logic clk = 0, rst = 0, start = 0;
  logic [7:0] count = 0;
  logic [15:0] on_ms = 0, off_ms = 0;
  logic led, busy, done;
`ifdef BLINK_SEQ_ABORT_EN
  logic abort = 0;
`endif
  int checks = 0, failures = 0;
  blink_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .MS_W(16), .CNT_W(8)) dut (
    .i_clk_100MHz(clk),
    .i_rst(rst),
    .i_start(start),
    .i_count(count),
    .i_on_ms(on_ms),
    .i_off_ms(off_ms),
`ifdef BLINK_SEQ_ABORT_EN
    .i_abort(abort),
`endif
    .o_led(led),
    .o_busy(busy),
    .o_done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // expected {led,busy,done} in cycle c after the accepting edge
  function automatic logic [2:0] model(input int cnt, input int on, input int off, input int c);
    int ton, toff, total;
    ton = (on == 0 ? 1 : on) * 10;
    toff = (off == 0 ? 1 : off) * 10;
    total = (cnt == 0) ? 1 : cnt * ton + (cnt - 1) * toff + 1;
    if (c > total) return 3'b000;
    if (c == total) return 3'b011;
    return {((c - 1) % (ton + toff)) < ton, 2'b10};
  endfunction
  task automatic run_seq(input string tag, input int cnt, input int on, input int off,
                         input int n, input int poke);
    @(negedge clk);
    check({tag, " idle"}, {29'd0, led, busy, done}, 32'd0);
    start = 1;
    count = 8'(cnt);
    on_ms = 16'(on);
    off_ms = 16'(off);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start = (c == poke);
      if (c == poke) begin
        count = 8'd5;
        on_ms = 16'd7;
        off_ms = 16'd7;
      end
      check($sformatf("%s c%0d", tag, c), {29'd0, led, busy, done}, {29'd0, model(cnt, on, off, c)});
    end
    start = 0;
  endtask
  initial begin
    #2 rst = 1;
    #1;
    check("rst led", {31'd0, led}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 0;
    run_seq("t2", 2, 3, 2, 82, 0);
    run_seq("t3", 0, 3, 2, 2, 0);
    run_seq("t4", 1, 0, 0, 11, 5);
    run_seq("t4b", 1, 2, 5, 21, 0);
    run_seq("t5", 2, 3, 2, 15, 0);
    @(negedge clk);
    check("t5 pre led", {31'd0, led}, 32'd1);
    #1 rst = 1;
    #1;
    check("t5 async led", {31'd0, led}, 32'd0);
    check("t5 async busy", {31'd0, busy}, 32'd0);
    #1 rst = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("t5 post c%0d", c), {29'd0, led, busy, done}, 32'd0);
    end
    run_seq("t5b", 2, 3, 2, 82, 0);
    run_seq("t7", 3, 2, 0, 82, 0);
`ifdef BLINK_SEQ_ABORT_EN
    @(negedge clk);
    check("t6 idle", {29'd0, led, busy, done}, 32'd0);
    start = 1;
    count = 8'd3;
    on_ms = 16'd1;
    off_ms = 16'd2;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 0;
      abort = (c == 15);
      check($sformatf("t6 c%0d", c), {29'd0, led, busy, done},
            (c <= 10) ? 32'd6 : (c <= 15) ? 32'd2 : (c == 16) ? 32'd3 : 32'd0);
    end
    abort = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
